// File: rtl/rv32i_types.sv
// -----------------------------------------------------------------------------
// rv32i_types
// Shared definitions for the branch resolve unit:
//   rv32i_word  - 32-bit machine word
//   bp_meta_t   - predictor metadata carried from IF capture down to MEM
//   PC_STEP     - sequential fetch increment
//   CNT_MAX     - saturation value of the performance counters
//   pred_taken  - predicted-taken flag derived from a metadata slot
// -----------------------------------------------------------------------------
package rv32i_types;

   typedef logic [31:0] rv32i_word;

   typedef struct packed {
      logic      valid;
      rv32i_word pc;
      logic      hit;
      logic      prediction;
      logic      is_jal;
      rv32i_word target;
   } bp_meta_t;

   localparam rv32i_word   PC_STEP = 32'd4;
   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   // A predictor entry redirects fetch when it hits and is either a
   // predicted-taken branch or a jal (always taken).
   function automatic logic pred_taken(input bp_meta_t m);
      return m.hit & (m.prediction | m.is_jal);
   endfunction

endpackage

// File: rtl/bru_meta_pipe.sv
// -----------------------------------------------------------------------------
// bru_meta_pipe
// Shift register of predictor metadata, one slot per pipeline stage from IF
// capture to MEM. The last slot is the MEM slot.
// Parameters:
//   PIPE_DEPTH  number of slots (legal 2..4)
// Ports:
//   clk, rst    clock, asynchronous active-high reset (clears every field)
//   stall       holds every slot
//   flush       clears every valid bit, including the slot-0 capture;
//               wins over the shift
//   in          metadata captured into slot 0
//   out         MEM slot contents
// -----------------------------------------------------------------------------
module bru_meta_pipe
   import rv32i_types::*;
#(
   parameter int PIPE_DEPTH = 3
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     stall,
   input  logic     flush,
   input  bp_meta_t in,
   output bp_meta_t out
);

   bp_meta_t slot_r [PIPE_DEPTH];

   // Slot storage: reset, flush-invalidate, shift or hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            slot_r[k] <= '0;
         end
      end else if (flush) begin
         // No shift on a flush edge; the fields stay but nothing is live.
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            slot_r[k].valid <= 1'b0;
         end
      end else if (!stall) begin
         slot_r[0] <= in;
         for (int k = 1; k < PIPE_DEPTH; k++) begin
            slot_r[k] <= slot_r[k-1];
         end
      end else begin
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            slot_r[k] <= slot_r[k];
         end
      end
   end

   assign out = slot_r[PIPE_DEPTH-1];

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Carries predictor lookup metadata from IF to MEM, compares the prediction
// with the resolved outcome there, and produces the predictor write controls,
// the squash/redirect request and optional performance counters.
// Configuration macro:
//   BRU_PERF_CNT_EN  when defined, br_count / mispredict_count are saturating
//                    counters; otherwise both ports are tied to zero.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   stall                     global stall; freezes slots, zeroes outputs
//   IF_valid, IF_PC, IF_hit, IF_prediction, IF_is_jal, IF_target
//                             fetch-side predictor lookup result
//   MEM_is_br, MEM_is_jal_in, MEM_taken, MEM_target
//                             resolved control-flow info at MEM
//   update, replace, branch_result, MEM_is_jal, target_in, MEM_PC
//                             predictor write controls / data / index
//   flush, redirect_pc        squash request and fetch redirect address
//   br_count, mispredict_count performance counters
// -----------------------------------------------------------------------------
module branch_resolve_unit
   import rv32i_types::*;
#(
   parameter int PIPE_DEPTH = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        IF_valid,
   input  logic [31:0] IF_PC,
   input  logic        IF_hit,
   input  logic        IF_prediction,
   input  logic        IF_is_jal,
   input  logic [31:0] IF_target,
   input  logic        MEM_is_br,
   input  logic        MEM_is_jal_in,
   input  logic        MEM_taken,
   input  logic [31:0] MEM_target,
   output logic        update,
   output logic        replace,
   output logic        branch_result,
   output logic        MEM_is_jal,
   output logic [31:0] target_in,
   output logic [31:0] MEM_PC,
   output logic        flush,
   output logic [31:0] redirect_pc,
   output logic [31:0] br_count,
   output logic [31:0] mispredict_count
);

   bp_meta_t if_meta_s;
   bp_meta_t mem_meta_s;
   logic     pt_s;
   logic     at_s;
   logic     ctrl_s;
   logic     tgt_diff_s;
   logic     mispredict_s;
   logic     active_s;

   assign if_meta_s = '{valid:      IF_valid,
                        pc:         IF_PC,
                        hit:        IF_hit,
                        prediction: IF_prediction,
                        is_jal:     IF_is_jal,
                        target:     IF_target};

   bru_meta_pipe #(
      .PIPE_DEPTH (PIPE_DEPTH)
   ) u_meta_pipe (
      .clk   (clk),
      .rst   (rst),
      .stall (stall),
      .flush (flush),
      .in    (if_meta_s),
      .out   (mem_meta_s)
   );

   assign pt_s       = pred_taken(mem_meta_s);
   assign at_s       = MEM_is_jal_in | (MEM_is_br & MEM_taken);
   assign ctrl_s     = MEM_is_br | MEM_is_jal_in;
   assign tgt_diff_s = (mem_meta_s.target != MEM_target);
   // A non-control instruction that the predictor called taken also lands
   // here through pt != at.
   assign mispredict_s = mem_meta_s.valid &
                         ((pt_s != at_s) | (pt_s & at_s & tgt_diff_s));
   // Outputs are live only outside stall and reset so each MEM event is
   // reported exactly once and reset shows all zeros.
   assign active_s = !stall & !rst;

   // Resolution outputs, gated to zero while stalled or in reset.
   always_comb begin
      update        = 1'b0;
      replace       = 1'b0;
      flush         = 1'b0;
      branch_result = 1'b0;
      MEM_is_jal    = 1'b0;
      target_in     = 32'd0;
      MEM_PC        = 32'd0;
      redirect_pc   = 32'd0;
      if (active_s) begin
         update        = mem_meta_s.valid & ctrl_s & mem_meta_s.hit;
         replace       = mem_meta_s.valid & ctrl_s & at_s &
                         (!mem_meta_s.hit | tgt_diff_s);
         flush         = mispredict_s;
         branch_result = at_s;
         MEM_is_jal    = MEM_is_jal_in;
         target_in     = MEM_target;
         MEM_PC        = mem_meta_s.pc;
         if (at_s) begin
            redirect_pc = MEM_target;
         end else begin
            redirect_pc = mem_meta_s.pc + PC_STEP;
         end
      end else begin
         update        = 1'b0;
         replace       = 1'b0;
         flush         = 1'b0;
         branch_result = 1'b0;
         MEM_is_jal    = 1'b0;
         target_in     = 32'd0;
         MEM_PC        = 32'd0;
         redirect_pc   = 32'd0;
      end
   end

`ifdef BRU_PERF_CNT_EN
   logic [31:0] br_count_r;
   logic [31:0] mispredict_count_r;

   // Saturating counters of resolved control instructions and flushes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_count_r         <= 32'd0;
         mispredict_count_r <= 32'd0;
      end else begin
         if (!stall && mem_meta_s.valid && ctrl_s && (br_count_r != CNT_MAX)) begin
            br_count_r <= br_count_r + 32'd1;
         end else begin
            br_count_r <= br_count_r;
         end
         if (flush && (mispredict_count_r != CNT_MAX)) begin
            mispredict_count_r <= mispredict_count_r + 32'd1;
         end else begin
            mispredict_count_r <= mispredict_count_r;
         end
      end
   end

   assign br_count         = br_count_r;
   assign mispredict_count = mispredict_count_r;
`else
   assign br_count         = 32'd0;
   assign mispredict_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed bench for branch_resolve_unit (PIPE_DEPTH = 3). Inputs change 1 time
// unit after the rising edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

   localparam int DEPTH = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        IF_valid;
   logic [31:0] IF_PC;
   logic        IF_hit;
   logic        IF_prediction;
   logic        IF_is_jal;
   logic [31:0] IF_target;
   logic        MEM_is_br;
   logic        MEM_is_jal_in;
   logic        MEM_taken;
   logic [31:0] MEM_target;
   logic        update;
   logic        replace;
   logic        branch_result;
   logic        MEM_is_jal;
   logic [31:0] target_in;
   logic [31:0] MEM_PC;
   logic        flush;
   logic [31:0] redirect_pc;
   logic [31:0] br_count;
   logic [31:0] mispredict_count;

   int n_cmp = 0;
   int n_err = 0;

   branch_resolve_unit #(.PIPE_DEPTH(DEPTH)) dut (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .IF_valid         (IF_valid),
      .IF_PC            (IF_PC),
      .IF_hit           (IF_hit),
      .IF_prediction    (IF_prediction),
      .IF_is_jal        (IF_is_jal),
      .IF_target        (IF_target),
      .MEM_is_br        (MEM_is_br),
      .MEM_is_jal_in    (MEM_is_jal_in),
      .MEM_taken        (MEM_taken),
      .MEM_target       (MEM_target),
      .update           (update),
      .replace          (replace),
      .branch_result    (branch_result),
      .MEM_is_jal       (MEM_is_jal),
      .target_in        (target_in),
      .MEM_PC           (MEM_PC),
      .flush            (flush),
      .redirect_pc      (redirect_pc),
      .br_count         (br_count),
      .mispredict_count (mispredict_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_if(input logic v, input logic [31:0] pc, input logic hit,
                         input logic pred, input logic jal, input logic [31:0] tgt);
      IF_valid      = v;
      IF_PC         = pc;
      IF_hit        = hit;
      IF_prediction = pred;
      IF_is_jal     = jal;
      IF_target     = tgt;
   endtask

   task automatic set_mem(input logic br, input logic jal, input logic taken,
                          input logic [31:0] tgt);
      MEM_is_br     = br;
      MEM_is_jal_in = jal;
      MEM_taken     = taken;
      MEM_target    = tgt;
      #1;
   endtask

   // Empty every slot, then walk one entry down to the MEM slot.
   task automatic load_one(input logic [31:0] pc, input logic hit, input logic pred,
                           input logic jal, input logic [31:0] tgt);
      stall = 1'b0;
      set_if(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      MEM_is_br = 1'b0; MEM_is_jal_in = 1'b0; MEM_taken = 1'b0; MEM_target = 32'd0;
      for (int i = 0; i < DEPTH; i++) tick();
      set_if(1'b1, pc, hit, pred, jal, tgt);
      tick();
      IF_valid = 1'b0;
      for (int i = 1; i < DEPTH; i++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      stall = 1'b0;
      set_if(1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h200);
      MEM_is_br = 1'b1; MEM_is_jal_in = 1'b1; MEM_taken = 1'b1; MEM_target = 32'h60;
      #2;
      n_cmp++;
      if ({update, replace, flush, branch_result, MEM_is_jal} !== 5'b00000) begin
         n_err++;
         $display("FAIL reset_ctl: got %b want 00000",
                  {update, replace, flush, branch_result, MEM_is_jal});
      end
      n_cmp++;
      if ({redirect_pc, MEM_PC, target_in} !== 96'd0) begin
         n_err++;
         $display("FAIL reset_data: got %h %h %h want 0 0 0", redirect_pc, MEM_PC, target_in);
      end
      n_cmp++;
      if ({br_count, mispredict_count} !== 64'd0) begin
         n_err++;
         $display("FAIL reset_cnt: got %0d %0d want 0 0", br_count, mispredict_count);
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_cold_branch();
      load_one(32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
      set_mem(1'b1, 1'b0, 1'b1, 32'h60);
      n_cmp++;
      if ({update, replace, flush, branch_result} !== 4'b0111) begin
         n_err++;
         $display("FAIL cold_ctl: got %b want 0111", {update, replace, flush, branch_result});
      end
      n_cmp++;
      if (redirect_pc !== 32'h60 || MEM_PC !== 32'h40 || target_in !== 32'h60) begin
         n_err++;
         $display("FAIL cold_data: got %h %h %h want 60 40 60", redirect_pc, MEM_PC, target_in);
      end
   endtask

   task automatic test_correct_hit();
      load_one(32'h50, 1'b1, 1'b1, 1'b0, 32'h80);
      set_mem(1'b1, 1'b0, 1'b1, 32'h80);
      n_cmp++;
      if ({update, replace, flush} !== 3'b100 || redirect_pc !== 32'h80) begin
         n_err++;
         $display("FAIL hit_ok: got %b %h want 100 80", {update, replace, flush}, redirect_pc);
      end
   endtask

   task automatic test_wrong_dir();
      load_one(32'h1C, 1'b1, 1'b1, 1'b0, 32'h80);
      set_mem(1'b1, 1'b0, 1'b0, 32'h80);
      n_cmp++;
      if ({update, replace, flush, branch_result} !== 4'b1010 || redirect_pc !== 32'h20) begin
         n_err++;
         $display("FAIL wrong_dir: got %b %h want 1010 20",
                  {update, replace, flush, branch_result}, redirect_pc);
      end
   endtask

   task automatic test_jal_target();
      load_one(32'h10, 1'b1, 1'b0, 1'b1, 32'h100);
      set_mem(1'b0, 1'b1, 1'b0, 32'h200);
      n_cmp++;
      if ({update, replace, flush, branch_result, MEM_is_jal} !== 5'b11111 ||
          redirect_pc !== 32'h200) begin
         n_err++;
         $display("FAIL jal_target: got %b %h want 11111 200",
                  {update, replace, flush, branch_result, MEM_is_jal}, redirect_pc);
      end
   endtask

   task automatic test_alias();
      load_one(32'h30, 1'b1, 1'b1, 1'b0, 32'h90);
      set_mem(1'b0, 1'b0, 1'b1, 32'h90);
      n_cmp++;
      if ({update, replace, flush} !== 3'b001 || redirect_pc !== 32'h34) begin
         n_err++;
         $display("FAIL alias: got %b %h want 001 34", {update, replace, flush}, redirect_pc);
      end
      // PC+4 wraps at the top of the address space.
      load_one(32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 32'h90);
      set_mem(1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++;
      if (flush !== 1'b1 || redirect_pc !== 32'h0) begin
         n_err++;
         $display("FAIL wrap: got %b %h want 1 00000000", flush, redirect_pc);
      end
   endtask

   task automatic test_invalid_mem();
      load_one(32'h44, 1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < DEPTH; i++) tick();   // entry leaves MEM, bubbles follow
      set_mem(1'b1, 1'b0, 1'b1, 32'h70);
      n_cmp++;
      if ({update, replace, flush} !== 3'b000) begin
         n_err++;
         $display("FAIL invalid_mem: got %b want 000", {update, replace, flush});
      end
   endtask

   task automatic test_stall_flush();
      load_one(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < DEPTH; i++) tick();
      set_if(1'b1, 32'h1C, 1'b1, 1'b1, 1'b0, 32'h80);
      tick();
      set_if(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      set_if(1'b1, 32'h24, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      // 0x1C is at MEM with two valid younger slots behind it.
      stall = 1'b1;
      set_if(1'b1, 32'h28, 1'b0, 1'b0, 1'b0, 32'h0);
      set_mem(1'b1, 1'b0, 1'b0, 32'h80);
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({update, replace, flush} !== 3'b000 || redirect_pc !== 32'h0) begin
            n_err++;
            $display("FAIL stall_hold[%0d]: got %b %h want 000 0", i,
                     {update, replace, flush}, redirect_pc);
         end
         tick();
      end
      stall = 1'b0;
      #1;
      n_cmp++;
      if ({update, flush} !== 2'b11 || redirect_pc !== 32'h20 || MEM_PC !== 32'h1C) begin
         n_err++;
         $display("FAIL stall_release: got %b %h %h want 11 20 1c",
                  {update, flush}, redirect_pc, MEM_PC);
      end
      tick();
      // Any surviving slot (incl. the capture of 0x28) would be a cold taken
      // branch here and raise replace/flush.
      IF_valid = 1'b0;
      set_mem(1'b1, 1'b0, 1'b1, 32'h60);
      for (int i = 0; i < DEPTH; i++) begin
         n_cmp++;
         if ({update, replace, flush} !== 3'b000) begin
            n_err++;
            $display("FAIL post_flush[%0d]: got %b want 000", i, {update, replace, flush});
         end
         tick();
      end
   endtask

   task automatic test_rst_mid_stall();
      load_one(32'h1C, 1'b1, 1'b1, 1'b0, 32'h80);
      stall = 1'b1;
      set_mem(1'b1, 1'b0, 1'b0, 32'h80);
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({update, replace, flush} !== 3'b000 || redirect_pc !== 32'h0 || MEM_PC !== 32'h0 ||
          br_count !== 32'd0 || mispredict_count !== 32'd0) begin
         n_err++;
         $display("FAIL rst_mid_stall: got %b %h %h %0d %0d want 000 0 0 0 0",
                  {update, replace, flush}, redirect_pc, MEM_PC, br_count, mispredict_count);
      end
      #1;
      rst = 1'b0;
      stall = 1'b0;
      #1;
      n_cmp++;
      if ({update, replace, flush} !== 3'b000 || MEM_PC !== 32'h0) begin
         n_err++;
         $display("FAIL rst_discard: got %b %h want 000 0", {update, replace, flush}, MEM_PC);
      end
   endtask

   initial begin
      test_reset();
      test_cold_branch();
      test_correct_hit();
      test_wrong_dir();
      test_jal_target();
      test_alias();
      test_invalid_mem();
      test_stall_flush();
      test_rst_mid_stall();
`ifndef BRU_PERF_CNT_EN
      n_cmp++;
      if ({br_count, mispredict_count} !== 64'd0) begin
         n_err++;
         $display("FAIL cnt_tied: got %0d %0d want 0 0", br_count, mispredict_count);
      end
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
